// File: rtl/key_debounce_pkg.sv
// ---------------------------------------------------------------------------
// key_debounce_pkg : board-wide timing constants and key FSM state encoding
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package key_debounce_pkg;

  localparam int CLK_FREQ_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS      = 20;
  localparam int LONG_MS          = 1000;
  localparam int DEBOUNCE_CYC_DEF = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
  localparam int LONG_CYC_DEF     = (CLK_FREQ_HZ / 1000) * LONG_MS;
  localparam int CNT_W_DEF        = $clog2(LONG_CYC_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff : generic two-flop synchroniser with configurable reset value
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce : synchronise and debounce an active-low key, emit level,
//                press, release and long-press events
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int LONG_CYC     = LONG_CYC_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic sys_clk_i,
  input  logic sys_rst_i,
  input  logic key_n_i,
  output logic key_level_o,
  output logic key_press_o,
  output logic key_release_o,
  output logic key_long_o
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYC);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

  logic       key_n_sync;
  logic       k_s;
  key_state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic       long_done_q;
  logic       level_q;
  logic       press_q;
  logic       release_q;
  logic       long_q;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk_i (sys_clk_i),
    .rst_i (sys_rst_i),
    .d_i   (key_n_i),
    .q_o   (key_n_sync)
  );

  assign k_s = ~key_n_sync;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          level_q     <= 1'b0;
          long_done_q <= 1'b0;
          if (k_s) begin
            state_q <= ST_PRESS_WAIT;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!k_s) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= ST_PRESSED;
            level_q <= 1'b1;
            press_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!k_s) begin
            state_q <= ST_RELEASE_WAIT;
            cnt_q   <= CNT_ONE;
          end else if (cnt_q != LONG_MAX) begin
            cnt_q <= cnt_q + CNT_ONE;
            // long_done survives release bounces so one hold fires once
            if (cnt_q == LONG_LAST && !long_done_q) begin
              long_q      <= 1'b1;
              long_done_q <= 1'b1;
            end
          end
        end
        ST_RELEASE_WAIT: begin
          if (k_s) begin
            state_q <= ST_PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q     <= ST_IDLE;
            level_q     <= 1'b0;
            release_q   <= 1'b1;
            long_done_q <= 1'b0;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign key_level_o   = level_q;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;
  assign key_long_o    = long_q;

endmodule

`default_nettype wire
